mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage RISC-V pipeline, directly downstream of the EX/MEM register.

---
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: formats loads/stores, runs a req/ack data-memory access, registers the MEM/WB bundle.
// Latency: 1 edge for non-memory ops and faults, (memory latency + 1) edges for accesses.
// Backpressure: stall_out holds EX/MEM while a request is outstanding; no combinational input path.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] RD2_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic        wb_MemToReg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic [31:0] fault_addr
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q;
    logic [31:0]     addr_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            rw_q, m2r_q, store_q;

    logic        is_mem, illegal, misalign, fault, timeout_hit;
    logic [31:0] st_wdata, ld_ext;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign stall_out   = (state_q == WAIT);
    assign is_mem      = MemRead_in | MemWrite_in;
    assign illegal     = (MemRead_in & MemWrite_in) | (funct3_in == 3'b011) | (funct3_in[2:1] == 2'b11)
                       | (MemWrite_in & funct3_in[2]);
    assign misalign    = ((funct3_in[1:0] == 2'b01) & ALUResult_in[0])
                       | ((funct3_in[1:0] == 2'b10) & (ALUResult_in[1:0] != 2'b00));
    assign fault       = illegal | misalign;
    assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        st_wdata = RD2_in;
        st_be    = 4'b1111;
        case (funct3_in[1:0])
            2'b00: begin
                st_wdata = {4{RD2_in[7:0]}};
                st_be    = 4'b0001 << ALUResult_in[1:0];
            end
            2'b01: begin
                st_wdata = {2{RD2_in[15:0]}};
                st_be    = ALUResult_in[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Lane select uses the captured byte offset; rdata is only valid alongside ack.
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (addr_q[1:0])
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            2'b11:   ld_byte = dmem_rdata[31:24];
            default: ;
        endcase
        ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in && is_mem && !fault) state_d = WAIT;
            WAIT:    if (dmem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0; addr_q <= '0; f3_q <= '0; rd_q <= '0;
            rw_q <= 1'b0; m2r_q <= 1'b0; store_q <= 1'b0;
            dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_addr <= '0; dmem_wdata <= '0; dmem_be <= '0;
            wb_valid <= 1'b0; wb_RegWrite <= 1'b0; wb_MemToReg <= 1'b0; wb_rd <= '0;
            wb_alu_result <= '0; wb_load_data <= '0;
            misalign_out <= 1'b0; bus_err_out <= 1'b0; fault_addr <= '0;
        end else begin
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            if (state_q == IDLE) begin
                wb_valid <= 1'b0;
                if (valid_in) begin
                    if (!is_mem || fault) begin
                        wb_valid      <= 1'b1;
                        wb_RegWrite   <= RegWrite_in & (rd_in != 5'd0) & ~is_mem;
                        wb_MemToReg   <= MemToReg_in;
                        wb_rd         <= rd_in;
                        wb_alu_result <= ALUResult_in;
                        wb_load_data  <= '0;
                        if (is_mem) begin
                            misalign_out <= 1'b1;
                            fault_addr   <= ALUResult_in;
                        end
                    end else begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_in;
                        dmem_addr  <= {ALUResult_in[31:2], 2'b00};
                        dmem_wdata <= MemWrite_in ? st_wdata : 32'd0;
                        dmem_be    <= MemWrite_in ? st_be : 4'b0000;
                        cnt_q      <= '0;
                        addr_q     <= ALUResult_in;
                        f3_q       <= funct3_in;
                        rd_q       <= rd_in;
                        rw_q       <= RegWrite_in & (rd_in != 5'd0);
                        m2r_q      <= MemToReg_in;
                        store_q    <= MemWrite_in;
                    end
                end
            end else if (dmem_ack || timeout_hit) begin
                // Ack wins over a timeout landing on the same cycle.
                dmem_req      <= 1'b0;
                dmem_we       <= 1'b0;
                dmem_be       <= 4'b0000;
                wb_valid      <= 1'b1;
                wb_MemToReg   <= m2r_q;
                wb_rd         <= rd_q;
                wb_alu_result <= addr_q;
                wb_RegWrite   <= dmem_ack & rw_q & ~store_q;
                wb_load_data  <= (dmem_ack && !store_q) ? ld_ext : 32'd0;
                if (!dmem_ack) begin
                    bus_err_out <= 1'b1;
                    fault_addr  <= addr_q;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage with a variable-latency memory responder.
module tb_mem_access_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] ALUResult_in = '0, RD2_in = '0;
    logic [2:0]  funct3_in = '0;
    logic [4:0]  rd_in = '0;
    logic        RegWrite_in = 1'b0, MemToReg_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_RegWrite, wb_MemToReg, misalign_out, bus_err_out;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_load_data, fault_addr;

    mem_access_stage #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .valid_in(valid_in), .ALUResult_in(ALUResult_in),
        .RD2_in(RD2_in), .funct3_in(funct3_in), .rd_in(rd_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .misalign_out(misalign_out),
        .bus_err_out(bus_err_out), .fault_addr(fault_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic        rw, m2r, chk_ld, mis, berr;
        logic [31:0] alu, ld;
    } wb_exp_t;
    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        we;
        logic [3:0]  be;
        int          lat;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int n_cmp = 0, n_err = 0;
    int stall_run = 0, last_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = (off >= 2'd2) ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Drives one instruction at a negedge and returns once the DUT has consumed it.
    task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic rw, input logic mr, input logic mw,
                         input int lat, input logic [31:0] rdata, input bit exp_wb);
        wb_exp_t  e;
        req_exp_t r;
        bit       bad;
        int       budget;
        bad = (mr && mw) || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (mw && f3[2])
              || (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        bad = bad && (mr || mw);
        e.rd = rd; e.m2r = mr; e.alu = addr; e.mis = bad; e.berr = 1'b0;
        e.rw = rw && rd != 0 && !mw && !bad && !(mr && lat < 0);
        e.berr = (mr || mw) && !bad && lat < 0;
        e.chk_ld = !bad && !e.berr;
        e.ld = mr ? model_load(f3, addr[1:0], rdata) : 32'd0;
        if (e.berr) e.rw = 1'b0;
        if (exp_wb) wb_q.push_back(e);
        if ((mr || mw) && !bad) begin
            r.addr = {addr[31:2], 2'b00}; r.we = mw; r.lat = lat; r.rdata = rdata;
            r.wdata = rs2; r.be = 4'b1111;
            if (!mw) r.be = 4'b0000;
            else if (f3[1:0] == 2'b00) begin r.wdata = {4{rs2[7:0]}}; r.be = 4'b0001 << addr[1:0]; end
            else if (f3[1:0] == 2'b01) begin r.wdata = {2{rs2[15:0]}}; r.be = addr[1] ? 4'b1100 : 4'b0011; end
            req_q.push_back(r);
        end
        @(negedge clock);
        valid_in = 1'b1; funct3_in = f3; rd_in = rd; ALUResult_in = addr; RD2_in = rs2;
        RegWrite_in = rw; MemToReg_in = mr; MemRead_in = mr; MemWrite_in = mw;
        budget = 40;
        while (stall_out && budget > 0) begin @(negedge clock); budget--; end
        if (budget == 0) check("issue_stuck", 32'd1, 32'd0);
        @(posedge clock);
        #1 valid_in = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        while ((wb_q.size() != 0 || stall_out) && budget > 0) begin @(negedge clock); budget--; end
        if (budget == 0) check("drain_timeout", 32'(wb_q.size()), 32'd0);
        @(negedge clock);
    endtask

    // Memory responder: checks the request on its first cycle, acks after the requested latency.
    initial begin
        int wcnt, cur_lat;
        logic [31:0] cur_rdata;
        req_exp_t r;
        wcnt = 0; cur_lat = -1; cur_rdata = '0;
        forever begin
            @(negedge clock);
            if (dmem_req) begin
                wcnt++;
                if (wcnt == 1) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                        cur_lat = -1;
                    end else begin
                        r = req_q.pop_front();
                        check("req_addr", dmem_addr, r.addr);
                        check("req_we", 32'(dmem_we), 32'(r.we));
                        check("req_be", 32'(dmem_be), 32'(r.be));
                        if (r.we) check("req_wdata", dmem_wdata, r.wdata);
                        cur_lat = r.lat; cur_rdata = r.rdata;
                    end
                end
                dmem_ack   = (wcnt == cur_lat);
                dmem_rdata = dmem_ack ? cur_rdata : 32'd0;
            end else begin
                wcnt = 0; dmem_ack = 1'b0; dmem_rdata = '0;
            end
        end
    end

    // WB monitor and stall-length tracker.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clock);
            if (stall_out) stall_run++;
            else if (stall_run != 0) begin last_stall = stall_run; stall_run = 0; end
            if (reset_n && wb_valid) begin
                if (wb_q.size() == 0) check("unexpected_wb", 32'd1, 32'd0);
                else begin
                    e = wb_q.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_regwrite", 32'(wb_RegWrite), 32'(e.rw));
                    check("wb_memtoreg", 32'(wb_MemToReg), 32'(e.m2r));
                    check("wb_alu", wb_alu_result, e.alu);
                    if (e.chk_ld) check("wb_load", wb_load_data, e.ld);
                    check("wb_flags", {30'd0, misalign_out, bus_err_out}, {30'd0, e.mis, e.berr});
                    if (e.mis || e.berr) check("fault_addr", fault_addr, e.alu);
                end
            end else if (reset_n) begin
                check("flags_idle", {30'd0, misalign_out, bus_err_out}, 32'd0);
            end
        end
    end

    initial begin
        #1 check("reset_outs", {dmem_req, stall_out, wb_valid, wb_RegWrite, misalign_out, bus_err_out},
                 32'd0);
        check("reset_fault_addr", fault_addr, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        // ALU ops, including x0 destination
        issue(3'b000, 5'd5, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b1);
        issue(3'b000, 5'd0, 32'h0000_5678, 32'd0, 1'b1, 1'b0, 1'b0, 0, 32'd0, 1'b1);
        drain();
        check("stall_after_alu", 32'(stall_out), 32'd0);
        // Loads with sign/zero extension and lane selection
        issue(3'b000, 5'd6, 32'h0000_1003, 32'd0, 1'b1, 1'b1, 1'b0, 3, 32'h80FF_FF00, 1'b1);
        drain();
        check("lb_stall_len", 32'(last_stall), 32'd3);
        issue(3'b100, 5'd7, 32'h0000_1003, 32'd0, 1'b1, 1'b1, 1'b0, 3, 32'h80FF_FF00, 1'b1);
        issue(3'b001, 5'd8, 32'h0000_1002, 32'd0, 1'b1, 1'b1, 1'b0, 2, 32'h80FF_FF00, 1'b1);
        issue(3'b101, 5'd9, 32'h0000_1000, 32'd0, 1'b1, 1'b1, 1'b0, 1, 32'h80FF_FF00, 1'b1);
        issue(3'b010, 5'd10, 32'h0000_1004, 32'd0, 1'b1, 1'b1, 1'b0, 1, 32'h1234_5678, 1'b1);
        drain();
        check("lw_min_stall", 32'(last_stall), 32'd1);
        // Stores
        issue(3'b001, 5'd11, 32'h0000_2002, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 2, 32'd0, 1'b1);
        issue(3'b000, 5'd12, 32'h0000_2001, 32'h0000_00EF, 1'b0, 1'b0, 1'b1, 1, 32'd0, 1'b1);
        issue(3'b010, 5'd13, 32'h0000_2004, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 2, 32'd0, 1'b1);
        drain();
        // Misaligned and illegal accesses
        issue(3'b010, 5'd14, 32'h0000_3001, 32'd0, 1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1);
        issue(3'b001, 5'd15, 32'h0000_3003, 32'd0, 1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b1);
        issue(3'b100, 5'd16, 32'h0000_3008, 32'd0, 1'b0, 1'b0, 1'b1, 0, 32'd0, 1'b1);
        drain();
        check("fault_addr_hold", fault_addr, 32'h0000_3008);
        // Timeout abort, then ack landing on the final allowed cycle
        issue(3'b010, 5'd17, 32'h0000_4000, 32'd0, 1'b1, 1'b1, 1'b0, -1, 32'd0, 1'b1);
        drain();
        check("timeout_stall_len", 32'(last_stall), 32'd4);
        check("timeout_req_low", 32'(dmem_req), 32'd0);
        issue(3'b010, 5'd18, 32'h0000_4004, 32'd0, 1'b1, 1'b1, 1'b0, 4, 32'hA5A5_5A5A, 1'b1);
        drain();
        // Reset during WAIT drops the request with no writeback
        issue(3'b010, 5'd19, 32'h0000_5000, 32'd0, 1'b1, 1'b1, 1'b0, -1, 32'd0, 1'b0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_outs", {stall_out, wb_valid, wb_RegWrite, dmem_we, misalign_out, bus_err_out}, 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        check("rst_wb_alu", wb_alu_result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        issue(3'b010, 5'd20, 32'h0000_6000, 32'd0, 1'b1, 1'b1, 1'b0, 2, 32'h0BAD_F00D, 1'b1);
        drain();
        check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        check("req_queue_empty", 32'(req_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
